// File: rtl/control_word_sequencer.sv
// Program buffer and playback sequencer that feeds control words to the datapath.
// Words are loaded over a valid/ready port and then played out one per clock.
module control_word_sequencer #(
    parameter int CW_WIDTH = 55,
    parameter int DEPTH    = 16,
    parameter int AW       = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_valid,
    input  logic [CW_WIDTH-1:0] load_data,
    output logic                load_ready,
    input  logic                clear,
    input  logic                start,
    input  logic                halt,
    input  logic                step,
    input  logic                loop_en,
    output logic [CW_WIDTH-1:0] control_word,
    output logic                cw_valid,
    output logic                busy,
    output logic                done,
    output logic [AW:0]         count
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [AW:0] FULL = DEPTH[AW:0];

    state_t              state;
    logic [CW_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]       pc;
    logic [AW-1:0]       iss_pc;
    logic                issue;
    logic                last;
    logic                idle_like;
    logic                load_fire;

    assign idle_like  = (state == IDLE) || (state == DONE);
    assign load_ready = idle_like && (count < FULL);
    // A clear in the same cycle drops the offered word.
    assign load_fire  = load_valid && load_ready && !clear;

    // Decide whether a word goes out at this edge and from which entry.
    always_comb begin
        issue  = 1'b0;
        iss_pc = pc;
        case (state)
            IDLE, DONE: begin
                if (start && !clear && (count != '0)) begin
                    issue  = 1'b1;
                    iss_pc = '0;
                end
            end
            RUN:     issue = !halt;
            PAUSE:   issue = start || step;
            default: issue = 1'b0;
        endcase
    end

    assign last = ({1'b0, iss_pc} == (count - 1'b1));

    always_ff @(posedge clk) begin
        if (load_fire && !rst)
            mem[count[AW-1:0]] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            pc           <= '0;
            control_word <= '0;
            cw_valid     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            control_word <= '0;
            cw_valid     <= 1'b0;
            done         <= 1'b0;

            if (idle_like) begin
                if (clear)
                    count <= '0;
                else if (load_fire)
                    count <= count + 1'b1;
                if (load_fire && (state == DONE))
                    state <= IDLE;
            end

            if ((state == RUN) && halt) begin
                state <= PAUSE;
                busy  <= 1'b1;
            end

            if (issue) begin
                control_word <= mem[iss_pc];
                cw_valid     <= 1'b1;
                if (last && !loop_en) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pc    <= '0;
                end else begin
                    pc    <= last ? '0 : iss_pc + 1'b1;
                    // A bare step while paused stays paused; everything else runs.
                    state <= ((state == PAUSE) && !start) ? PAUSE : RUN;
                    busy  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_control_word_sequencer.sv
// Bench for control_word_sequencer: directed scenarios followed by randomized
// playback control, each cycle compared against a queue-based program model.
module tb_control_word_sequencer;

    localparam int W = 55;
    localparam int D = 16;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         load_ready;
    logic         clear;
    logic         start;
    logic         halt;
    logic         step;
    logic         loop_en;
    logic [W-1:0] control_word;
    logic         cw_valid;
    logic         busy;
    logic         done;
    logic [4:0]   count;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] prog[$];
    int           mode = M_IDLE;
    int           pos  = 0;
    logic [W-1:0] e_cw;
    logic         e_vld, e_done;

    control_word_sequencer dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .clear(clear), .start(start), .halt(halt),
        .step(step), .loop_en(loop_en), .control_word(control_word),
        .cw_valid(cw_valid), .busy(busy), .done(done), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Play out entry a of the program; finishing or wrapping decided on program length.
    task automatic issue_word(input int a, input int next_mode);
        int n = prog.size();
        e_cw  = prog[a];
        e_vld = 1'b1;
        if (a == n - 1) begin
            if (loop_en) begin
                pos  = 0;
                mode = next_mode;
            end else begin
                mode   = M_DONE;
                e_done = 1'b1;
            end
        end else begin
            pos  = a + 1;
            mode = next_mode;
        end
    endtask

    task automatic model_edge();
        e_cw   = '0;
        e_vld  = 1'b0;
        e_done = 1'b0;
        if (rst) begin
            mode = M_IDLE;
            pos  = 0;
            prog.delete();
        end else begin
            case (mode)
                M_IDLE, M_DONE: begin
                    if (clear) begin
                        prog.delete();
                    end else begin
                        if (start && prog.size() > 0)
                            issue_word(0, M_RUN);
                        else if (load_valid && prog.size() < D) begin
                            prog.push_back(load_data);
                            mode = M_IDLE;
                        end
                    end
                end
                M_RUN: begin
                    if (halt) mode = M_PAUSE;
                    else      issue_word(pos, M_RUN);
                end
                default: begin
                    if (start)     issue_word(pos, M_RUN);
                    else if (step) issue_word(pos, M_PAUSE);
                end
            endcase
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("control_word", 64'(control_word), 64'(e_cw));
        chk("cw_valid", 64'(cw_valid), 64'(e_vld));
        chk("done", 64'(done), 64'(e_done));
        chk("busy", 64'(busy), 64'((mode == M_RUN) || (mode == M_PAUSE)));
        chk("count", 64'(count), 64'(prog.size()));
        chk("load_ready", 64'(load_ready),
            64'(((mode == M_IDLE) || (mode == M_DONE)) && (prog.size() < D)));
    endtask

    task automatic quiet();
        rst = 1'b0; load_valid = 1'b0; load_data = '0; clear = 1'b0;
        start = 1'b0; halt = 1'b0; step = 1'b0;
    endtask

    task automatic load_word(input logic [W-1:0] w);
        load_valid = 1'b1;
        load_data  = w;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        quiet();
        loop_en = 1'b0;

        // Reset state
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_ready", 64'(load_ready), 64'd1);

        // Three-word program, plain run to done
        load_word(55'h1); load_word(55'h2); load_word(55'h3);
        start = 1'b1; tick(); start = 1'b0;
        chk("first_word", 64'(control_word), 64'h1);
        for (int i = 0; i < 4; i++) tick();

        // Fill the buffer, then offer a 17th word
        pulse_clear();
        for (int i = 0; i < D; i++) load_word(W'(i + 32'h100));
        chk("full_ready", 64'(load_ready), 64'd0);
        load_word(55'h7777);
        chk("full_count", 64'(count), 64'd16);

        // Loop A,B then drop loop_en mid-run
        pulse_clear();
        load_word(55'hA); load_word(55'hB);
        loop_en = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        loop_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Halt, step, step, resume
        pulse_clear();
        for (int i = 1; i <= 4; i++) load_word(W'(i + 32'h40));
        start = 1'b1; tick(); start = 1'b0;
        halt = 1'b1; tick(); halt = 1'b0;
        tick();
        step = 1'b1; tick(); step = 1'b0;
        tick();
        step = 1'b1; tick(); step = 1'b0;
        chk("step_word3", 64'(control_word), 64'h43);
        start = 1'b1; tick(); start = 1'b0;
        chk("resume_word4", 64'(control_word), 64'h44);
        tick(); tick();

        // Start on empty program; clear beats a load
        pulse_clear();
        start = 1'b1; tick(); start = 1'b0;
        chk("empty_start_busy", 64'(busy), 64'd0);
        clear = 1'b1; load_valid = 1'b1; load_data = 55'h55;
        tick();
        quiet();
        chk("clear_wins_count", 64'(count), 64'd0);

        // Reset during RUN
        load_word(55'h9); load_word(55'h8); load_word(55'h7);
        start = 1'b1; tick(); start = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        tick();

        // Randomized rounds
        for (int r = 0; r < 10; r++) begin
            int n;
            quiet();
            pulse_clear();
            n = $urandom_range(1, D);
            for (int i = 0; i < n; i++) load_word(W'({$urandom(), $urandom()}));
            loop_en = 1'($urandom_range(0, 1));
            start = 1'b1; tick(); start = 1'b0;
            for (int c = 0; c < 50; c++) begin
                halt  = ($urandom_range(0, 7) == 0);
                start = ($urandom_range(0, 5) == 0);
                step  = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 9) == 0) loop_en = ~loop_en;
                rst   = ($urandom_range(0, 149) == 0);
                tick();
            end
        end
        quiet();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
